// File: rtl/stream_feed_fifo.sv
// First-word-fall-through valid/ready FIFO feeding the datapath stage's data input.
// Handshake flags come only from the registered fill level; clear_i flushes synchronously.
module stream_feed_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [AW:0]      level_o
);

    if (WIDTH < 1) begin : g_bad_width
        $error("stream_feed_fifo: WIDTH must be at least 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("stream_feed_fifo: DEPTH must be a power of two, at least 2");
    end

    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    always_comb begin
        s_ready_o = (count != LVL_FULL);
        m_valid_o = (count != '0);
        m_data_o  = m_valid_o ? mem[rd_ptr] : '0;
        level_o   = count;
        push      = s_valid_i && s_ready_o;
        pop       = m_valid_o && m_ready_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + LVL_ONE;
                2'b01:   count <= count - LVL_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately unreset; the level counter alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            mem[wr_ptr] <= s_data_i;
        end
    end

endmodule

// File: tb/tb_stream_feed_fifo.sv
// Self-checking bench for stream_feed_fifo: vector table, directed corner sequences,
// and a randomized run compared against a queue-based reference model.
module tb_stream_feed_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [AW:0]      level;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q[$];

    typedef struct {
        logic             clr;
        logic             sv;
        logic [WIDTH-1:0] sd;
        logic             mr;
        int               lvl;
        logic             v;
        logic [WIDTH-1:0] d;
        logic             rdy;
    } vec_t;

    vec_t tbl[17];

    stream_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (clear),
        .s_data_i (s_data),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .m_data_o (m_data),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready),
        .level_o  (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; the reference queue follows the FIFO rules for the current inputs.
    task automatic step();
        bit do_push;
        bit do_pop;
        do_push = s_valid && (q.size() != DEPTH);
        do_pop  = m_ready && (q.size() != 0);
        @(posedge clk);
        if (clear) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(s_data);
        end
        #1;
    endtask

    task automatic drive(input logic c, input logic sv, input logic [WIDTH-1:0] sd, input logic mr);
        clear   = c;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".level"}, int'(level), q.size());
        chk({tag, ".valid"}, int'(m_valid), int'(q.size() != 0));
        chk({tag, ".ready"}, int'(s_ready), int'(q.size() != DEPTH));
        chk({tag, ".data"}, int'(m_data), (q.size() != 0) ? int'(q[0]) : 0);
    endtask

    initial begin
        //          clr  sv   sd     mr    lvl v     d      rdy
        tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b1, 8'h11, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b1, 8'h11, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 8'h44, 1'b0, 4, 1'b1, 8'h11, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h55, 1'b0, 4, 1'b1, 8'h11, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h55, 1'b1, 3, 1'b1, 8'h22, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 4, 1'b1, 8'h22, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'h66, 1'b1, 0, 1'b0, 8'h00, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1, 1'b1, 8'h3C, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 8'h77, 1'b0, 1, 1'b1, 8'h77, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 8'h81, 1'b0, 1, 1'b1, 8'h81, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 8'h82, 1'b0, 2, 1'b1, 8'h81, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 8'h83, 1'b0, 3, 1'b1, 8'h81, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 8'h55, 1'b0, 0, 1'b0, 8'h00, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};

        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        q.delete();
        chk("reset.level", int'(level), 0);
        chk("reset.valid", int'(m_valid), 0);
        chk("reset.ready", int'(s_ready), 1);
        chk("reset.data", int'(m_data), 0);

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].sv, tbl[i].sd, tbl[i].mr);
            step();
            chk($sformatf("vec%0d.level", i), int'(level), tbl[i].lvl);
            chk($sformatf("vec%0d.valid", i), int'(m_valid), int'(tbl[i].v));
            chk($sformatf("vec%0d.data", i), int'(m_data), int'(tbl[i].d));
            chk($sformatf("vec%0d.ready", i), int'(s_ready), int'(tbl[i].rdy));
        end

        // Full FIFO: a pop in the full cycle must not let the waiting word in that same edge.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
            step();
        end
        chk("full.level", int'(level), DEPTH);
        chk("full.ready", int'(s_ready), 0);
        drive(1'b0, 1'b1, 8'hA4, 1'b0);
        step();
        chk("full_hold.level", int'(level), DEPTH);
        chk("full_hold.data", int'(m_data), 'hA0);
        drive(1'b0, 1'b1, 8'hA4, 1'b1);
        step();
        chk("full_pop.level", int'(level), DEPTH - 1);
        chk("full_pop.data", int'(m_data), 'hA1);
        drive(1'b0, 1'b1, 8'hA4, 1'b0);
        step();
        chk("refill.level", int'(level), DEPTH);
        for (int i = 1; i <= DEPTH; i++) begin
            chk($sformatf("drain%0d.data", i), int'(m_data), 'hA0 + i);
            drive(1'b0, 1'b0, '0, 1'b1);
            step();
        end
        chk("drained.valid", int'(m_valid), 0);

        // Steady stream: level holds at one while pointers wrap repeatedly.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b1);
            step();
            chk($sformatf("stream%0d.level", i), int'(level), 1);
            chk($sformatf("stream%0d.data", i), int'(m_data), i);
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        chk("stream_end.level", int'(level), 0);

        // Asynchronous reset mid-cycle with two words stored.
        drive(1'b0, 1'b1, 8'h21, 1'b0);
        step();
        drive(1'b0, 1'b1, 8'h22, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("prearst.level", int'(level), 2);
        #2 rst = 1'b1;
        q.delete();
        #1;
        chk("arst.level", int'(level), 0);
        chk("arst.valid", int'(m_valid), 0);
        chk("arst.data", int'(m_data), 0);
        #3 rst = 1'b0;
        drive(1'b0, 1'b1, 8'h7E, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("post_arst.level", int'(level), 1);
        chk("post_arst.data", int'(m_data), 'h7E);
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        chk("post_arst_pop.level", int'(level), 0);

        // Randomized traffic with producer-side hold while not accepted.
        drive(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            bit held;
            held = s_valid && !clear && (q.size() == DEPTH);
            if (!held) begin
                s_valid = ($urandom_range(0, 99) < 60);
                s_data  = 8'($urandom);
            end
            m_ready = ($urandom_range(0, 99) < 50);
            clear   = ($urandom_range(0, 99) < 3);
            step();
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_feed_fifo.md
Name: stream_feed_fifo

Overview:
- Synchronous valid/ready FIFO that sits directly upstream of the datapath stage and drives its `data_i[WIDTH-1:0]` input.
- Decouples a bursty producer from the consuming stage. Buffers up to DEPTH words and reports its fill level.
- Provides a synchronous flush for error recovery.
- Single clock domain.

Parameters:
- WIDTH, 8, data word width in bits; must be ≥1. WIDTH = 0 is illegal and must trip an elaboration error.
- DEPTH, 4, number of storage entries; power of two, ≥2.
- AW, $clog2(DEPTH), derived pointer width; not to be overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; asynchronous and active-high.
- clear_i  input  1  synchronous flush; discards all contents.
- s_data_i  input  WIDTH  write data from producer.
- s_valid_i  input  1  producer has a word on s_data_i.
- s_ready_o  output  1  FIFO can accept a word this cycle.
- m_data_o  output  WIDTH  read data to consuming stage.
- m_valid_o  output  1  m_data_o holds a valid word.
- m_ready_i  input  1  consumer accepts m_data_o this cycle.
- level_o  output  AW+1  number of stored words, 0..DEPTH.

Behaviour:
- Reset (rst_i high, asynchronous): write pointer = 0, read pointer = 0, level_o = 0, m_valid_o = 0, s_ready_o = 1, m_data_o = 0.
  - Storage array is not reset.
  - Reset mid-burst drops all contents immediately. No partial word survives.
- Push: occurs on a rising edge when s_valid_i && s_ready_o.
  - The word is written at the write pointer.
  - The write pointer increments modulo DEPTH and wraps from DEPTH-1 to 0.
- Pop: occurs on a rising edge when m_valid_o && m_ready_i.
  - The read pointer increments modulo DEPTH with the same wrap rule.
- s_ready_o = (level_o != DEPTH).
  - Depends only on registered state, never on m_ready_i. There is no combinational ready path.
  - When full, a simultaneous pop does not enable a push in that same cycle.
- m_valid_o = (level_o != 0).
- m_data_o = storage[read pointer] when m_valid_o is 1; forced to 0 when m_valid_o is 0.
  - This is first-word-fall-through: the head word is presented without a read request.
- Latency:
  - A word pushed into an empty FIFO at edge N appears on m_data_o with m_valid_o = 1 after edge N, i.e. one cycle later.
  - Words are never reordered.
- level_o update per edge:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Simultaneous push and pop at 0 < level < DEPTH: both take effect and level_o is unchanged.
- Empty with s_valid_i high and m_ready_i high: only the push occurs, because no pop is possible when m_valid_o is 0.
- clear_i high at an edge:
  - Pointers → 0, level_o → 0.
  - Any push or pop in that cycle is ignored; a word offered that cycle is discarded even though s_ready_o was 1.
  - clear_i has lower priority than rst_i.
- Handshake rule:
  - The producer must hold s_data_i and s_valid_i until accepted.
  - The FIFO's outputs obey the same rule: once m_valid_o rises, m_data_o stays stable until popped or cleared.
- All arithmetic on pointers is AW bits unsigned with natural wrap. level_o is AW+1 bits, so DEPTH itself is representable.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with m_ready_i = 0 → level_o = 1, 2, 3; m_valid_o rises one cycle after the first push; m_data_o = 0x11.
2. Fill a DEPTH = 4 FIFO with 0xA0..0xA3 while holding s_valid_i high with 0xA4 → s_ready_o = 0 at level 4 and 0xA4 is not accepted; assert m_ready_i for one cycle → 0xA0 is popped; 0xA4 is accepted on the following edge.
3. Steady stream: s_valid_i = m_ready_i = 1 for 20 cycles with incrementing data 0..19 → level_o holds at 1 after the first cycle; output is 0..19 in order; pointers wrap several times.
4. Load 3 words, assert clear_i in the same cycle as s_valid_i = 1 with 0x55 → next cycle level_o = 0, m_valid_o = 0, m_data_o = 0; 0x55 never appears.
5. Assert rst_i asynchronously mid-cycle with level_o = 2 → m_valid_o and level_o drop to 0 without waiting for a clock edge; after release, a push of 0x7E is delivered as the first word.
6. Empty FIFO with m_ready_i = 1 and push 0x3C → no pop occurs that cycle; 0x3C appears next cycle and pops on the following edge; level_o goes 0 → 1 → 0.
